// File: rtl/alu_pkg.sv
// alu_pkg: constants shared by the ALU and its built-in self-test engine.
// Holds the opcode encodings, datapath width, the LFSR/MISR feedback polynomial
// and the BIST sequencer state type.
package alu_pkg;

  localparam int XLEN        = 64;
  localparam int ALU_NUM_OPS = 10;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  // Right-shifting Galois form of x^64 + x^63 + x^61 + x^60 + 1
  // (tap k of the polynomial lands on bit k-1 of the mask).
  localparam logic [XLEN-1:0] LFSR_POLY = 64'hD800_0000_0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } bist_state_e;

endpackage

// File: rtl/alu_bist_if.sv
// alu_bist_if: control/status handshake of the BIST engine plus the ALU operand
// bus it takes over. The master side is the BIST engine; the slave side is the
// ALU together with whoever requests the self-test.
// Optional: ALU_BIST_FLAGS_EN adds the ALU carry/borrow/overflow flags.
interface alu_bist_if;
  import alu_pkg::*;

  logic            start;
  logic            busy;
  logic            done;
  logic            pass;
  logic [XLEN-1:0] signature;
  logic [XLEN-1:0] alu_a;
  logic [XLEN-1:0] alu_b;
  logic [3:0]      alu_op;
  logic [XLEN-1:0] alu_out;
`ifdef ALU_BIST_FLAGS_EN
  logic            cout;
  logic            borrow;
  logic            overflowadd;
  logic            overflowsub;

  modport master (
    input  start, alu_out, cout, borrow, overflowadd, overflowsub,
    output busy, done, pass, signature, alu_a, alu_b, alu_op
  );

  modport slave (
    output start, alu_out, cout, borrow, overflowadd, overflowsub,
    input  busy, done, pass, signature, alu_a, alu_b, alu_op
  );
`else
  modport master (
    input  start, alu_out,
    output busy, done, pass, signature, alu_a, alu_b, alu_op
  );

  modport slave (
    output start, alu_out,
    input  busy, done, pass, signature, alu_a, alu_b, alu_op
  );
`endif

endinterface

// File: rtl/bist_lfsr.sv
// bist_lfsr: one combinational step of the 64-bit Galois shift register, with an
// XOR-inject input so the same cell serves as pattern generator (inject = 0)
// and as signature compactor (inject = data to absorb).
module bist_lfsr
  import alu_pkg::*;
(
  input  logic [XLEN-1:0] state_in,
  input  logic [XLEN-1:0] inject,
  output logic [XLEN-1:0] state_out
);

  // Shift right, fold the polynomial back in when a one falls out, then absorb.
  always_comb begin
    state_out = {1'b0, state_in[XLEN-1:1]} ^ (state_in[0] ? LFSR_POLY : '0) ^ inject;
  end

endmodule

// File: rtl/alu_bist.sv
// alu_bist: self-test sequencer for the 64-bit ALU. On start it drives every
// opcode over LFSR-generated operand pairs, compacts each ALU result into a
// MISR and compares the final signature with EXPECTED_SIG.
// Operands/opcode are registered, so a vector issued at one edge is absorbed
// at the next and the signature is complete one cycle after the last issue.
// Optional: define ALU_BIST_FLAGS_EN to also compact the ALU flags.
module alu_bist #(
  parameter int          XLEN         = 64,
  parameter int          NUM_VECTORS  = 256,
  parameter logic [63:0] SEED         = 64'h1,
  parameter logic [63:0] EXPECTED_SIG = 64'h0
) (
  input  logic       clk,
  input  logic       rst,
  alu_bist_if.master bus
);
  import alu_pkg::*;

  localparam logic [XLEN-1:0] SEED_EFF = (SEED == 64'h0) ? 64'h1 : SEED;
  localparam int              VW       = $clog2(NUM_VECTORS + 1);
  localparam logic [VW-1:0]   LAST_VEC = VW'(NUM_VECTORS - 1);

  bist_state_e     state_q, state_d;
  logic [XLEN-1:0] lfsr_q, lfsr_next;
  logic [XLEN-1:0] misr_q, misr_next, misr_inject;
  logic [XLEN-1:0] a_q;
  logic [3:0]      op_q, alu_op_q;
  logic [VW-1:0]   vec_q;
  logic            issuing_q, valid_q, last_q, pass_q;
  logic            start_ok, issue, issue_last, finish;

  assign start_ok   = bus.start && (state_q != ST_RUN);
  assign issue      = (state_q == ST_RUN) && issuing_q;
  assign issue_last = (op_q == ALU_SLTU) && (vec_q == LAST_VEC);
  assign finish     = valid_q && last_q;

`ifdef ALU_BIST_FLAGS_EN
  assign misr_inject = bus.alu_out ^ {{(XLEN-4){1'b0}},
                                      bus.cout, bus.borrow, bus.overflowadd, bus.overflowsub};
`else
  assign misr_inject = bus.alu_out;
`endif

  bist_lfsr u_gen (
    .state_in  (lfsr_q),
    .inject    ('0),
    .state_out (lfsr_next)
  );

  bist_lfsr u_misr (
    .state_in  (misr_q),
    .inject    (misr_inject),
    .state_out (misr_next)
  );

  // Sequencer state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next state: start is only honoured when not already running.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus.start) state_d = ST_RUN;
      ST_RUN:  if (finish)    state_d = ST_DONE;
      ST_DONE: if (bus.start) state_d = ST_RUN;
      default: state_d = ST_IDLE;
    endcase
  end

  // Vector generator, operand registers and signature compactor.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q    <= '0;
      misr_q    <= '0;
      a_q       <= '0;
      op_q      <= ALU_ADD;
      alu_op_q  <= ALU_ADD;
      vec_q     <= '0;
      issuing_q <= 1'b0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      pass_q    <= 1'b0;
    end else if (start_ok) begin
      lfsr_q    <= SEED_EFF;
      misr_q    <= '0;
      a_q       <= '0;
      op_q      <= ALU_ADD;
      alu_op_q  <= ALU_ADD;
      vec_q     <= '0;
      issuing_q <= 1'b1;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      pass_q    <= 1'b0;
    end else begin
      valid_q <= issue;
      if (issue) begin
        a_q      <= lfsr_q;
        alu_op_q <= op_q;
        last_q   <= issue_last;
        if (op_q == ALU_SLTU) begin
          op_q   <= ALU_ADD;
          lfsr_q <= lfsr_next;
          vec_q  <= vec_q + VW'(1);
        end else begin
          op_q <= op_q + 4'd1;
        end
        if (issue_last) issuing_q <= 1'b0;
      end else begin
        a_q      <= '0;
        alu_op_q <= ALU_ADD;
        last_q   <= 1'b0;
      end
      if (valid_q) misr_q <= misr_next;
      if (finish)  pass_q <= (misr_next == EXPECTED_SIG);
    end
  end

  assign bus.busy      = (state_q == ST_RUN);
  assign bus.done      = (state_q == ST_DONE);
  assign bus.pass      = pass_q;
  assign bus.signature = misr_q;
  assign bus.alu_a     = a_q;
  assign bus.alu_b     = {a_q[XLEN/2-1:0], a_q[XLEN-1:XLEN/2]};
  assign bus.alu_op    = alu_op_q;

endmodule

// File: tb/tb_alu_bist.sv
// tb_alu_bist: scoreboard bench for alu_bist. Stimulus pushes the expected
// operand vectors and final signature/pass into queues; a negedge monitor pops
// and compares whenever the DUT drives a vector or raises done.
module tb_alu_bist;
  import alu_pkg::*;

  localparam int NV = 4;
  localparam int T  = NV * ALU_NUM_OPS;
  localparam logic [63:0] MODEL_POLY = 64'hD800_0000_0000_0000;

  // Reference Galois step of x^64+x^63+x^61+x^60+1.
  function automatic logic [63:0] gstep(input logic [63:0] s);
    return (s >> 1) ^ ({64{s[0]}} & MODEL_POLY);
  endfunction

  // Reference ALU.
  function automatic logic [63:0] alu_fn(input logic [3:0] op, input logic [63:0] a,
                                         input logic [63:0] b);
    logic [63:0] r;
    case (op)
      4'd0: r = a + b;
      4'd1: r = a - b;
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = a << b[5:0];
      4'd6: r = a >> b[5:0];
      4'd7: r = $signed(a) >>> b[5:0];
      4'd8: r = {63'b0, $signed(a) < $signed(b)};
      4'd9: r = {63'b0, a < b};
      default: r = 64'h0;
    endcase
    return r;
  endfunction

  // Reference signature of a full run; fault zeroes every SUB result.
  function automatic logic [63:0] model_sig(input logic [63:0] seed, input int nv,
                                            input bit fault);
    logic [63:0] s, sig, a, r;
    s   = (seed == 64'h0) ? 64'h1 : seed;
    sig = 64'h0;
    for (int v = 0; v < nv; v++) begin
      for (int op = 0; op < 10; op++) begin
        a   = s;
        r   = (fault && op == 1) ? 64'h0 : alu_fn(4'(op), a, {a[31:0], a[63:32]});
        sig = gstep(sig) ^ r;
      end
      s = gstep(s);
    end
    return sig;
  endfunction

  localparam logic [63:0] GOLDEN       = model_sig(64'h1, NV, 1'b0);
  localparam logic [63:0] GOLDEN_SMALL = model_sig(64'h0, 1, 1'b0);

  typedef struct packed {
    logic [63:0] a;
    logic [3:0]  op;
    logic [31:0] cyc;
  } vec_t;

  typedef struct packed {
    logic [63:0] sig;
    logic        pass;
    logic [31:0] cyc;
  } res_t;

  vec_t vec_exp[$];
  res_t res_exp[$];

  logic clk = 1'b0;
  logic rst = 1'b1;
  bit   sub_fault = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  alu_bist_if bus();
  alu_bist_if bus2();

  alu_bist #(.XLEN(64), .NUM_VECTORS(NV), .SEED(64'h1), .EXPECTED_SIG(GOLDEN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  alu_bist #(.XLEN(64), .NUM_VECTORS(1), .SEED(64'h0), .EXPECTED_SIG(GOLDEN_SMALL)) dut_small (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // ALU stand-ins, with an optional fault on SUB for the main DUT.
  always_comb begin
    bus.alu_out = alu_fn(bus.alu_op, bus.alu_a, bus.alu_b);
    if (sub_fault && bus.alu_op == ALU_SUB) bus.alu_out = 64'h0;
  end

  always_comb begin
    bus2.alu_out = alu_fn(bus2.alu_op, bus2.alu_a, bus2.alu_b);
  end

`ifdef ALU_BIST_FLAGS_EN
  assign bus.cout         = 1'b0;
  assign bus.borrow       = 1'b0;
  assign bus.overflowadd  = 1'b0;
  assign bus.overflowsub  = 1'b0;
  assign bus2.cout        = 1'b0;
  assign bus2.borrow      = 1'b0;
  assign bus2.overflowadd = 1'b0;
  assign bus2.overflowsub = 1'b0;
`endif

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Queue every vector and the final result of a run whose start is sampled at edge k.
  task automatic pushRun(input bit fault, input int k);
    logic [63:0] s;
    logic [63:0] sig;
    res_t r;
    s = 64'h1;
    for (int v = 0; v < NV; v++) begin
      for (int op = 0; op < ALU_NUM_OPS; op++)
        vec_exp.push_back('{a: s, op: 4'(op), cyc: 32'(k + 1 + v * ALU_NUM_OPS + op)});
      s = gstep(s);
    end
    sig   = model_sig(64'h1, NV, fault);
    r.sig = sig;
    r.pass = (sig == GOLDEN);
    r.cyc = 32'(k + 1 + T);
    res_exp.push_back(r);
  endtask

  task automatic applyStimulus(input bit fault, input bit hold);
    sub_fault = fault;
    bus.start = 1'b1;
    pushRun(fault, cyc + 1);
    @(posedge clk); #1;
    if (!hold) bus.start = 1'b0;
  endtask

  task automatic waitDone(input int limit);
    int n = 0;
    while (!bus.done && n < limit) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("done_timeout", {63'b0, bus.done}, 64'h1);
  endtask

  // Monitor: compare every driven vector and every completed run.
  logic done_prev = 1'b0;
  always @(negedge clk) begin
    vec_t e;
    res_t r;
    if (bus.busy && bus.alu_a != 64'h0) begin
      if (vec_exp.size() == 0) begin
        checkOutput("unexpected_vector", bus.alu_a, 64'h0);
      end else begin
        e = vec_exp.pop_front();
        checkOutput("vec_a", bus.alu_a, e.a);
        checkOutput("vec_b", bus.alu_b, {e.a[31:0], e.a[63:32]});
        checkOutput("vec_op", {60'b0, bus.alu_op}, {60'b0, e.op});
        checkOutput("vec_cycle", 64'(cyc), {32'b0, e.cyc});
      end
    end else if (!bus.busy) begin
      checkOutput("idle_a", bus.alu_a, 64'h0);
      checkOutput("idle_op", {60'b0, bus.alu_op}, 64'h0);
    end
    if (bus.done && !done_prev) begin
      if (res_exp.size() == 0) begin
        checkOutput("unexpected_done", {63'b0, bus.done}, 64'h0);
      end else begin
        r = res_exp.pop_front();
        checkOutput("signature", bus.signature, r.sig);
        checkOutput("pass", {63'b0, bus.pass}, {63'b0, r.pass});
        checkOutput("done_cycle", 64'(cyc), {32'b0, r.cyc});
        checkOutput("busy_at_done", {63'b0, bus.busy}, 64'h0);
      end
    end
    done_prev <= bus.done;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.start  = 1'b0;
    bus2.start = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_busy", {63'b0, bus.busy}, 64'h0);
    checkOutput("rst_done", {63'b0, bus.done}, 64'h0);
    checkOutput("rst_pass", {63'b0, bus.pass}, 64'h0);
    checkOutput("rst_sig", bus.signature, 64'h0);
    checkOutput("rst_a", bus.alu_a, 64'h0);
    checkOutput("rst_b", bus.alu_b, 64'h0);
    checkOutput("rst_op", {60'b0, bus.alu_op}, 64'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    $display("[TB] single-pair run, SEED=0");
    bus2.start = 1'b1;
    @(posedge clk); #1;
    bus2.start = 1'b0;
    checkOutput("small_busy_k", {63'b0, bus2.busy}, 64'h1);
    @(posedge clk); #1;
    checkOutput("small_a_k1", bus2.alu_a, 64'h1);
    checkOutput("small_b_k1", bus2.alu_b, 64'h0000_0001_0000_0000);
    checkOutput("small_op_k1", {60'b0, bus2.alu_op}, 64'h0);
    repeat (9) @(posedge clk);
    #1;
    checkOutput("small_op_k10", {60'b0, bus2.alu_op}, 64'h9);
    @(posedge clk); #1;
    checkOutput("small_done_k11", {63'b0, bus2.done}, 64'h1);
    checkOutput("small_busy_k11", {63'b0, bus2.busy}, 64'h0);
    checkOutput("small_pass", {63'b0, bus2.pass}, 64'h1);
    checkOutput("small_sig", bus2.signature, GOLDEN_SMALL);
    checkOutput("small_a_after", bus2.alu_a, 64'h0);

    $display("[TB] golden run");
    applyStimulus(1'b0, 1'b0);
    waitDone(T + 10);

    $display("[TB] SUB fault run");
    applyStimulus(1'b1, 1'b0);
    waitDone(T + 10);
    checkOutput("fault_sig_differs", {63'b0, bus.signature != GOLDEN}, 64'h1);
    sub_fault = 1'b0;

    $display("[TB] rerun from done");
    applyStimulus(1'b0, 1'b0);
    waitDone(T + 10);

    $display("[TB] reset mid-run");
    applyStimulus(1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("midrst_busy", {63'b0, bus.busy}, 64'h0);
    checkOutput("midrst_done", {63'b0, bus.done}, 64'h0);
    checkOutput("midrst_sig", bus.signature, 64'h0);
    checkOutput("midrst_a", bus.alu_a, 64'h0);
    checkOutput("midrst_b", bus.alu_b, 64'h0);
    checkOutput("midrst_op", {60'b0, bus.alu_op}, 64'h0);
    vec_exp.delete();
    res_exp.delete();
    rst = 1'b0;
    @(posedge clk); #1;
    applyStimulus(1'b0, 1'b0);
    waitDone(T + 10);

    $display("[TB] start held through run");
    applyStimulus(1'b0, 1'b1);
    waitDone(T + 10);
    bus.start = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("vectors_left", 64'(vec_exp.size()), 64'h0);
    checkOutput("results_left", 64'(res_exp.size()), 64'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_bist.md
# alu_bist

Synthesizable built-in self-test engine for the 64-bit integer ALU. It sits beside the ALU in the execute stage and, on request, takes over the ALU operand/opcode inputs. It sweeps every opcode (ADD..SLTU) over pseudo-random operand pairs from an LFSR. It compacts every ALU result into a MISR signature, then reports pass/fail against a compile-time golden signature.

## Interface
Parameters:
- XLEN, 64, datapath width (fixed at 64; LFSR polynomial is defined for 64).
- NUM_VECTORS, 256, operand pairs per run; each pair is applied to all 10 opcodes.
- SEED, 64'h1, initial LFSR state; a value of 0 is replaced by 64'h1.
- EXPECTED_SIG, 64'h0, golden MISR signature for the attached ALU.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  level-sampled run request; honoured only in IDLE or DONE.
- busy  output  1  high while vectors are being applied.
- done  output  1  high from end of run until next accepted start or rst.
- pass  output  1  valid while done; 1 iff signature == EXPECTED_SIG.
- signature  output  64  current MISR value.
- alu_a, alu_b  output  64 each  ALU operands.
- alu_op  output  4  ALU opcode.
- alu_out  input  64  ALU result (combinational from alu_a/alu_b/alu_op).
- cout, borrow, overflowadd, overflowsub  input  1 each  ALU flags; present only with ALU_BIST_FLAGS_EN.

## Operation
- States: IDLE → RUN → DONE. DONE → RUN on start; any state → IDLE on rst.
- Start accepted: LFSR ← SEED (or 1 if SEED==0), MISR ← 0, op counter ← 0, vector counter ← 0, done ← 0, busy ← 1.
- Operands: alu_a = lfsr; alu_b = {lfsr[31:0], lfsr[63:32]}.
- Sequencing: the opcode is the inner loop 4'b0000 (ADD) … 4'b1001 (SLTU). After SLTU, the LFSR advances one step and op wraps to ADD. Opcodes 1010–1111 are never driven.
- LFSR: 64-bit Galois, polynomial x^64+x^63+x^61+x^60+1, one step per operand pair.
- MISR: sig ← step(sig) ^ alu_out, using the same polynomial, once per applied vector.
- Total vectors T = 10·NUM_VECTORS. After the T-th absorb: busy ← 0, done ← 1, and pass ← (next sig == EXPECTED_SIG).
- Outside RUN: alu_a = alu_b = 0 and alu_op = 0 (ADD). signature holds its last value until next start or rst.
- start while busy: ignored, with no restart.

## Timing
- Reset values: busy=0, done=0, pass=0, signature=0, alu_a=0, alu_b=0, alu_op=0, state IDLE.
- If start is sampled at edge k, vector i (0-based) is driven on outputs from edge k+1+i.
- alu_out for vector i is absorbed at edge k+2+i.
- At edge k+1+T: done=1, busy=0, pass valid. Run latency is T+1 cycles.
- Throughput is one vector per cycle with no bubbles at opcode or LFSR wrap.
- rst mid-run: at the next edge all outputs return to reset values. A later run is bit-identical to an uninterrupted one.

## Configuration
- ALU_BIST_FLAGS_EN defined: the four flag ports exist. Each absorb also XORs {cout, borrow, overflowadd, overflowsub} into sig[3:0].
- ALU_BIST_FLAGS_EN undefined: the flag ports are absent and only alu_out is compacted. EXPECTED_SIG differs between the two builds.

## Structure
- Shared package alu_pkg holds:
  - the opcode constants ALU_ADD=4'b0000, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU=4'b1001;
  - ALU_NUM_OPS=10 and XLEN=64;
  - the LFSR polynomial constant;
  - the state enum.
- One sub-module, bist_lfsr: a 64-bit Galois step with optional XOR-inject input. It is instantiated twice, once as the generator (inject=0) and once as the MISR.

## Test plan
- Reset: hold rst 3 cycles → busy=0, done=0, pass=0, signature=0, alu_a=alu_b=0, alu_op=0.
- NUM_VECTORS=1, SEED=1, start at edge k:
  - edge k+1: alu_a=64'h1, alu_b=64'h0000_0001_0000_0000, alu_op=0;
  - edge k+10: alu_op=9;
  - edge k+11: done=1, busy=0.
- NUM_VECTORS=4 with the real ALU and EXPECTED_SIG taken from a bench model (LFSR, ALU and MISR) → pass=1, signature equals the model value.
- Same run with alu_out forced to 0 on every SUB vector → pass=0, signature ≠ EXPECTED_SIG.
- rst asserted at vector 5, then start → outputs zero the cycle after rst. The new run's signature equals an uninterrupted run's signature.
- start held high through the whole run → no restart, done at k+1+T. start pulsed in DONE → rerun, identical signature. SEED=0 → first alu_a=64'h1.
